// File: rtl/execute_result_queue.sv
// In-order DEPTH-entry buffer between execute and memory-access/writeback.
// Pushes stall behind a queued branch/trap/xRET until it drains; flush discards everything.
module execute_result_queue #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32,
  parameter int OP_WIDTH   = 32,
  parameter int INT_WIDTH  = 32,
  parameter int FP_WIDTH   = 64,
  parameter int TRAP_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       flush,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [ADDR_WIDTH-1:0]      inPc,
  input  logic [INSN_WIDTH-1:0]      inInsn,
  input  logic [OP_WIDTH-1:0]        inOp,
  input  logic [INT_WIDTH-1:0]       inDstInt,
  input  logic [FP_WIDTH-1:0]        inDstFp,
  input  logic                       inBranchTaken,
  input  logic [ADDR_WIDTH-1:0]      inBranchTarget,
  input  logic                       inTrapValid,
  input  logic [TRAP_WIDTH-1:0]      inTrapInfo,
  input  logic                       inTrapReturn,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [ADDR_WIDTH-1:0]      outPc,
  output logic [INSN_WIDTH-1:0]      outInsn,
  output logic [OP_WIDTH-1:0]        outOp,
  output logic [INT_WIDTH-1:0]       outDstInt,
  output logic [FP_WIDTH-1:0]        outDstFp,
  output logic                       outBranchTaken,
  output logic [ADDR_WIDTH-1:0]      outBranchTarget,
  output logic                       outTrapValid,
  output logic [TRAP_WIDTH-1:0]      outTrapInfo,
  output logic                       outTrapReturn,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       redirectPending
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // Bit offsets of each field inside one packed storage entry.
  localparam int OFF_PC   = 0;
  localparam int OFF_INSN = OFF_PC + ADDR_WIDTH;
  localparam int OFF_OP   = OFF_INSN + INSN_WIDTH;
  localparam int OFF_INT  = OFF_OP + OP_WIDTH;
  localparam int OFF_FP   = OFF_INT + INT_WIDTH;
  localparam int OFF_BT   = OFF_FP + FP_WIDTH;
  localparam int OFF_BTGT = OFF_BT + 1;
  localparam int OFF_TV   = OFF_BTGT + ADDR_WIDTH;
  localparam int OFF_TI   = OFF_TV + 1;
  localparam int OFF_TR   = OFF_TI + TRAP_WIDTH;
  localparam int ENTRY_W  = OFF_TR + 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               redirect_q, redirect_d;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               in_ready;
  logic               out_valid;
  logic               push;
  logic               pop;
  logic               in_redirect;

  assign in_ready    = (count_q < CNT_FULL) && !redirect_q;
  assign out_valid   = (count_q != '0);
  assign push        = inValid && in_ready && !flush;
  assign pop         = out_valid && outReady && !flush;
  assign in_redirect = inBranchTaken | inTrapValid | inTrapReturn;

  assign in_entry = {inTrapReturn, inTrapInfo, inTrapValid, inBranchTarget,
                     inBranchTaken, inDstFp, inDstInt, inOp, inInsn, inPc};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    redirect_d = redirect_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      redirect_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
      // A redirect entry is always the youngest, so popping the last entry retires it.
      if (push && in_redirect) begin
        redirect_d = 1'b1;
      end else if (pop && count_q == CNT_ONE) begin
        redirect_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      redirect_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      redirect_q <= redirect_d;
    end
  end

  // Storage holds no reset: contents are meaningless until written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && wr_ptr_q == PTR_W'(i)) begin
        mem[i] <= in_entry;
      end
    end
  end

  always_comb begin
    head_entry = mem[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (rd_ptr_q == PTR_W'(i)) begin
        head_entry = mem[i];
      end
    end
  end

  assign inReady         = in_ready;
  assign outValid        = out_valid;
  assign count           = count_q;
  assign redirectPending = redirect_q;
  assign outPc           = head_entry[OFF_PC +: ADDR_WIDTH];
  assign outInsn         = head_entry[OFF_INSN +: INSN_WIDTH];
  assign outOp           = head_entry[OFF_OP +: OP_WIDTH];
  assign outDstInt       = head_entry[OFF_INT +: INT_WIDTH];
  assign outDstFp        = head_entry[OFF_FP +: FP_WIDTH];
  assign outBranchTaken  = head_entry[OFF_BT];
  assign outBranchTarget = head_entry[OFF_BTGT +: ADDR_WIDTH];
  assign outTrapValid    = head_entry[OFF_TV];
  assign outTrapInfo     = head_entry[OFF_TI +: TRAP_WIDTH];
  assign outTrapReturn   = head_entry[OFF_TR];

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (!rstN)
    count_q <= CNT_FULL);
  // Popping an empty queue is a harmless no-op.
  a_pop_empty_noop: assert property (@(posedge clk) disable iff (!rstN)
    (outReady && !out_valid && !push && !flush) |=> (count_q == '0));
  // A push offered while not ready is simply ignored.
  a_push_refused_noop: assert property (@(posedge clk) disable iff (!rstN)
    (inValid && !in_ready && !pop && !flush) |=> (count_q == $past(count_q)));
  a_flush_clears: assert property (@(posedge clk) disable iff (!rstN)
    flush |=> (count_q == '0 && !redirect_q));
`endif

endmodule
